if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/pipe_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 tb/tb_if_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch front end: datapath width,
// sequential PC step and the fetch FSM state encoding.
package pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between the memory response port and the IF/ID register.
// Each entry holds {instr, pc_4}. Flush empties the queue in one cycle and
// wins over a simultaneous push or pop.
module fetch_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned W  = 2 * XLEN,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == DEPTH_C);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next pointer and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses in a small queue and handles taken-branch redirects by flushing
// the queue and discarding responses to requests already in flight.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal fetch; requests issued while a queue slot is reserved
// ST_DRAIN | waiting out stale responses after a redirect; no requests
module if_fetch_unit
  import pipe_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_push, fifo_pop;
  logic [XLEN-1:0]   rsp_pc_4;
  logic [CW:0]       reserved;
  logic              slot_free, req_fire, rsp_take;

  // Queue entries plus in-flight requests: a request only goes out if its
  // response is guaranteed a slot.
  assign reserved  = {1'b0, fifo_count} + {1'b0, outst_q};
  assign slot_free = !fifo_full && (reserved < DEPTH_C);

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_take  = imem_rsp_valid && (outst_q != '0);
  assign rsp_pc_4  = rsp_pc_q + PC_INC;
  assign fifo_push = rsp_take && (state_q == ST_RUN) && !redirect_valid;
  assign fifo_pop  = out_valid && out_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i ({imem_rsp_data, rsp_pc_4}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // FSM state and discard counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // Next state: a redirect discards everything still in flight after this
  // cycle, including a request that transfers alongside it.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      discard_d = outst_d;
      state_d   = (outst_d != '0) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN) begin
      if (rsp_take && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (discard_d == '0) state_d = ST_RUN;
    end
  end

  // Outputs: reset masks everything combinationally so nothing leaks during it.
  always_comb begin
    imem_req_valid = !rst && (state_q == ST_RUN) && slot_free;
    imem_req_addr  = pc_q;
    out_valid      = !rst && !fifo_empty;
    out_instr      = out_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
    out_pc_4       = out_valid ? fifo_head[XLEN-1:0]      : '0;
  end

  // Fetch PC, next-response PC and in-flight count updates.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q;
    if (redirect_valid) begin
      pc_d     = align_word(redirect_pc);
      rsp_pc_d = align_word(redirect_pc);
    end else begin
      if (req_fire)  pc_d     = pc_q + PC_INC;
      if (fifo_push) rsp_pc_d = rsp_pc_4;
    end
    if (req_fire && !rsp_take)      outst_d = outst_q + CW'(1);
    else if (!req_fire && rsp_take) outst_d = outst_q - CW'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model of
// configurable latency. Instruction data returned for address A is
// {16'hC0DE, A[15:0]}.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc_4;

  if_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_4       (out_pc_4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc4[$];
  logic [31:0] pop_instr[$];

  logic        s_req_valid, s_out_valid;
  logic [31:0] s_req_addr, s_out_instr, s_out_pc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pc4_at(input int i);
    if (i < pop_pc4.size()) return pop_pc4[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] instr_at(input int i);
    if (i < pop_instr.size()) return pop_instr[i];
    return 32'hDEAD_BEEF;
  endfunction

  // One clock: snapshot outputs at the falling edge, log handshakes, then
  // drive the memory response for the new cycle just after the rising edge.
  task automatic cycle();
    logic [31:0] a;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_out_instr = out_instr;
    s_out_pc4   = out_pc_4;
    if (imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (out_valid && out_ready) begin
      pop_pc4.push_back(out_pc_4);
      pop_instr.push_back(out_instr);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {16'hC0DE, a[15:0]};
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset(input string tag, input logic with_redir);
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = with_redir;
    redirect_pc    = 32'h0000_0800;
    lat            = 1;
    cycle();
    chk({tag, "_rst_req_valid"}, 32'(s_req_valid), 32'd0);
    chk({tag, "_rst_out_valid"}, 32'(s_out_valid), 32'd0);
    chk({tag, "_rst_out_instr"}, s_out_instr, 32'd0);
    chk({tag, "_rst_out_pc4"}, s_out_pc4, 32'd0);
    cycle();
    pend_addr.delete();
    pend_due.delete();
    req_log.delete();
    pop_pc4.delete();
    pop_instr.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    rst            = 1'b0;
  endtask

  initial begin
    // Streaming with latency 1; a redirect held during reset must be ignored.
    do_reset("t1", 1'b1);
    cycle();
    chk("t1_c0_req_valid", 32'(s_req_valid), 32'd1);
    chk("t1_c0_addr", s_req_addr, 32'h0000_0000);
    cycle();
    chk("t1_c1_addr", s_req_addr, 32'h0000_0004);
    chk("t1_c1_out_valid", 32'(s_out_valid), 32'd0);
    cycle();
    chk("t1_c2_addr", s_req_addr, 32'h0000_0008);
    chk("t1_c2_out_valid", 32'(s_out_valid), 32'd1);
    chk("t1_c2_pc4", s_out_pc4, 32'h0000_0004);
    chk("t1_c2_instr", s_out_instr, 32'hC0DE_0000);
    cycle();
    chk("t1_c3_addr", s_req_addr, 32'h0000_000C);
    chk("t1_c3_pc4", s_out_pc4, 32'h0000_0008);
    repeat (4) cycle();
    chk("t1_req3", req_at(3), 32'h0000_000C);
    chk("t1_pop0", pc4_at(0), 32'h0000_0004);
    chk("t1_pop1", pc4_at(1), 32'h0000_0008);
    chk("t1_pop2", pc4_at(2), 32'h0000_000C);
    chk("t1_pop3", pc4_at(3), 32'h0000_0010);
    chk("t1_pop3_instr", instr_at(3), 32'hC0DE_000C);

    // Consumer stalled: exactly DEPTH requests, then the queue drains in order.
    do_reset("t2", 1'b0);
    out_ready = 1'b0;
    repeat (10) cycle();
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_req_valid_full", 32'(s_req_valid), 32'd0);
    chk("t2_out_valid_full", 32'(s_out_valid), 32'd1);
    chk("t2_hold_pc4", s_out_pc4, 32'h0000_0004);
    out_ready = 1'b1;
    repeat (6) cycle();
    chk("t2_pop0", pc4_at(0), 32'h0000_0004);
    chk("t2_pop1", pc4_at(1), 32'h0000_0008);
    chk("t2_pop2", pc4_at(2), 32'h0000_000C);
    chk("t2_pop3", pc4_at(3), 32'h0000_0010);

    // Unsolicited response ignored; request held stable while not ready;
    // misaligned redirect with nothing in flight stays in RUN.
    do_reset("t3", 1'b0);
    imem_req_ready = 1'b0;
    cycle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    cycle();
    chk("t3_hold_valid", 32'(s_req_valid), 32'd1);
    chk("t3_hold_addr", s_req_addr, 32'h0000_0000);
    cycle();
    chk("t3_stray_rsp_out_valid", 32'(s_out_valid), 32'd0);
    chk("t3_hold_addr2", s_req_addr, 32'h0000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    cycle();
    chk("t3_redir_valid", 32'(s_req_valid), 32'd1);
    chk("t3_redir_addr", s_req_addr, 32'h0000_0200);
    cycle();
    chk("t3_redir_addr_next", s_req_addr, 32'h0000_0204);
    repeat (4) cycle();
    chk("t3_req0", req_at(0), 32'h0000_0200);
    chk("t3_pop0", pc4_at(0), 32'h0000_0204);

    // Latency 3, redirect while two are in flight and a third transfers.
    do_reset("t4", 1'b0);
    lat = 3;
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    chk("t4_redir_cycle_addr", s_req_addr, 32'h0000_0008);
    redirect_valid = 1'b0;
    cycle();
    chk("t4_drain_c3_valid", 32'(s_req_valid), 32'd0);
    cycle();
    cycle();
    chk("t4_drain_c5_valid", 32'(s_req_valid), 32'd0);
    cycle();
    chk("t4_c6_valid", 32'(s_req_valid), 32'd1);
    chk("t4_c6_addr", s_req_addr, 32'h0000_0100);
    chk("t4_c6_out_valid", 32'(s_out_valid), 32'd0);
    repeat (6) cycle();
    chk("t4_pop0", pc4_at(0), 32'h0000_0104);
    chk("t4_pop0_instr", instr_at(0), 32'hC0DE_0100);

    // Redirect together with a response and a pop.
    do_reset("t5", 1'b0);
    cycle();
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    cycle();
    chk("t5_coinc_out_valid", 32'(s_out_valid), 32'd1);
    chk("t5_coinc_pc4", s_out_pc4, 32'h0000_0008);
    redirect_valid = 1'b0;
    cycle();
    chk("t5_flushed_out_valid", 32'(s_out_valid), 32'd0);
    chk("t5_drain_req_valid", 32'(s_req_valid), 32'd0);
    cycle();
    chk("t5_resume_addr", s_req_addr, 32'h0000_0400);
    repeat (5) cycle();
    chk("t5_pop0", pc4_at(0), 32'h0000_0004);
    chk("t5_pop1", pc4_at(1), 32'h0000_0008);
    chk("t5_pop2", pc4_at(2), 32'h0000_0404);
    chk("t5_pop3", pc4_at(3), 32'h0000_0408);

    // PC wraps from FFFF_FFFC to 0.
    do_reset("t6", 1'b0);
    imem_req_ready = 1'b0;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    cycle();
    chk("t6_addr_top", s_req_addr, 32'hFFFF_FFFC);
    cycle();
    chk("t6_addr_wrap", s_req_addr, 32'h0000_0000);
    repeat (4) cycle();
    chk("t6_pop0", pc4_at(0), 32'h0000_0000);
    chk("t6_pop0_instr", instr_at(0), 32'hC0DE_FFFC);
    chk("t6_pop1", pc4_at(1), 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
